// File: rtl/alu_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : alu_sequencer_if
//  Description : Signal bundle between the ALU sequencer and its environment.
//                Carries the start strobe, the instruction ROM port, the ALU
//                operand/result port, status outputs and the debug read port.
//                master : sequencer side (drives ROM address, ALU operands,
//                         ALU_OP, Flags, Busy, Halted, Dbg_Data)
//                slave  : environment side (drives start, Instr_Data,
//                         ALU_Result, ALU_NZCV, Dbg_Sel)
//  Revision    : 1.0 - initial release
// ============================================================================
interface alu_sequencer_if #(
    parameter int ADDR_W = 4
);
    logic              start;       // begin execution at PC=0
    logic [ADDR_W-1:0] Instr_Addr;  // ROM address (= PC)
    logic [7:0]        Instr_Data;  // ROM data, combinational for Instr_Addr
    logic [7:0]        ALU_A;       // ALU operand A
    logic [7:0]        ALU_B;       // ALU operand B
    logic [2:0]        ALU_OP;      // ALU OP_Code, 000 outside EXEC
    logic [7:0]        ALU_Result;  // ALU result, combinational
    logic [3:0]        ALU_NZCV;    // ALU flags {N,Z,C,V}, combinational
    logic [3:0]        Flags;       // architectural NZCV register
    logic              Busy;        // executing (not IDLE/HALTED)
    logic              Halted;      // in HALTED
    logic [1:0]        Dbg_Sel;     // debug register select
    logic [7:0]        Dbg_Data;    // R[Dbg_Sel], combinational

    modport master (
        input  start, Instr_Data, ALU_Result, ALU_NZCV, Dbg_Sel,
        output Instr_Addr, ALU_A, ALU_B, ALU_OP, Flags, Busy, Halted, Dbg_Data
    );

    modport slave (
        output start, Instr_Data, ALU_Result, ALU_NZCV, Dbg_Sel,
        input  Instr_Addr, ALU_A, ALU_B, ALU_OP, Flags, Busy, Halted, Dbg_Data
    );
endinterface
`default_nettype wire

// File: rtl/alu_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : alu_sequencer
//  Description : Multi-cycle control/datapath stage around an external 8-bit
//                ALU. Fetches 8-bit instructions from a combinational ROM,
//                decodes them, holds a 4x8 register file, drives the ALU
//                operands/OP_Code, writes results back and keeps an
//                architectural NZCV flags register.
//  Ports       : clk  - single clock, all state on the rising edge
//                rst  - asynchronous active-high reset
//                bus  - alu_sequencer_if.master (start, ROM port, ALU port,
//                       Flags/Busy/Halted status, debug register read)
//  Instruction : [7:5] op, [4:3] rd, [2:1] rs, [0] ignored
//                000..100 ALU op R[rd] <= R[rd] op R[rs], Flags <= NZCV
//                101 MOV  R[rd] <= R[rs]
//                110 LDI  R[rd] <= next ROM byte (two-byte instruction)
//                111 HALT
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_sequencer #(
    parameter int ADDR_W = 4
) (
    input  wire logic           clk,
    input  wire logic           rst,
    alu_sequencer_if.master     bus
);

    // ------------------------------------------------------------------
    // Opcode constants
    // ------------------------------------------------------------------
    localparam logic [2:0] c_op_last_alu = 3'b100;
    localparam logic [2:0] c_op_mov      = 3'b101;
    localparam logic [2:0] c_op_ldi      = 3'b110;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_WB     = 3'd4,
        S_IMM    = 3'd5,
        S_HALTED = 3'd6
    } state_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_pc;
    logic [7:1]        r_ir;        // bit 0 of the instruction carries no meaning
    logic [7:0]        r_regs [4];
    logic [7:0]        r_opnd_a;
    logic [7:0]        r_opnd_b;
    logic [7:0]        r_res;
    logic [3:0]        r_nzcv;
    logic [3:0]        r_flags;

    // ------------------------------------------------------------------
    // Decode fields of the held instruction
    // ------------------------------------------------------------------
    logic [2:0] w_op;
    logic [1:0] w_rd;
    logic [1:0] w_rs;
    logic       w_op_is_alu;

    assign w_op        = r_ir[7:5];
    assign w_rd        = r_ir[4:3];
    assign w_rs        = r_ir[2:1];
    assign w_op_is_alu = (w_op <= c_op_last_alu);

    // ------------------------------------------------------------------
    // Control outputs of the FSM
    // ------------------------------------------------------------------
    logic [2:0] w_alu_op;
    logic       w_ir_load;
    logic       w_pc_inc;
    logic       w_pc_clr;
    logic       w_opnd_load;
    logic       w_res_load;
    logic       w_reg_we;
    logic [7:0] w_reg_wdata;
    logic       w_flags_we;

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM next-state and control decode
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_alu_op    = 3'b000;
        w_ir_load   = 1'b0;
        w_pc_inc    = 1'b0;
        w_pc_clr    = 1'b0;
        w_opnd_load = 1'b0;
        w_res_load  = 1'b0;
        w_reg_we    = 1'b0;
        w_reg_wdata = 8'h00;
        w_flags_we  = 1'b0;

        case (r_state)
            // start is only honoured while not busy; a restart from HALTED
            // keeps registers and Flags, only the PC returns to 0.
            S_IDLE, S_HALTED: begin
                if (bus.start) begin
                    w_pc_clr    = 1'b1;
                    w_state_nxt = S_FETCH;
                end
            end

            S_FETCH: begin
                w_ir_load   = 1'b1;
                w_pc_inc    = 1'b1;
                w_state_nxt = S_DECODE;
            end

            S_DECODE: begin
                w_opnd_load = 1'b1;
                if (w_op_is_alu) begin
                    w_state_nxt = S_EXEC;
                end else if (w_op == c_op_mov) begin
                    w_state_nxt = S_WB;
                end else if (w_op == c_op_ldi) begin
                    w_state_nxt = S_IMM;
                end else begin
                    w_state_nxt = S_HALTED;
                end
            end

            // Only ALU instructions ever reach EXEC; the guard keeps the
            // non-ALU opcodes off ALU_OP regardless.
            S_EXEC: begin
                w_alu_op    = w_op_is_alu ? w_op : 3'b000;
                w_res_load  = 1'b1;
                w_state_nxt = S_WB;
            end

            // MOV skips the ALU and writes the latched source operand.
            S_WB: begin
                w_reg_we    = 1'b1;
                w_reg_wdata = (w_op == c_op_mov) ? r_opnd_b : r_res;
                w_flags_we  = w_op_is_alu;
                w_state_nxt = S_FETCH;
            end

            // Second byte of LDI sits at the already-incremented PC.
            S_IMM: begin
                w_reg_we    = 1'b1;
                w_reg_wdata = bus.Instr_Data;
                w_pc_inc    = 1'b1;
                w_state_nxt = S_FETCH;
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc     <= '0;
            r_ir     <= '0;
            r_opnd_a <= 8'h00;
            r_opnd_b <= 8'h00;
            r_res    <= 8'h00;
            r_nzcv   <= 4'h0;
            r_flags  <= 4'h0;
            for (int i = 0; i < 4; i++) begin
                r_regs[i] <= 8'h00;
            end
        end else begin
            // PC is ADDR_W wide, so the increment wraps naturally.
            if (w_pc_clr) begin
                r_pc <= '0;
            end else if (w_pc_inc) begin
                r_pc <= r_pc + 1'b1;
            end

            if (w_ir_load) begin
                r_ir <= bus.Instr_Data[7:1];
            end

            // With rd == rs both latches capture the same register.
            if (w_opnd_load) begin
                r_opnd_a <= r_regs[w_rd];
                r_opnd_b <= r_regs[w_rs];
            end

            if (w_res_load) begin
                r_res  <= bus.ALU_Result;
                r_nzcv <= bus.ALU_NZCV;
            end

            if (w_reg_we) begin
                r_regs[w_rd] <= w_reg_wdata;
            end

            if (w_flags_we) begin
                r_flags <= r_nzcv;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.Instr_Addr = r_pc;
    assign bus.ALU_A      = r_opnd_a;
    assign bus.ALU_B      = r_opnd_b;
    assign bus.ALU_OP     = w_alu_op;
    assign bus.Flags      = r_flags;
    assign bus.Busy       = (r_state != S_IDLE) && (r_state != S_HALTED);
    assign bus.Halted     = (r_state == S_HALTED);
    assign bus.Dbg_Data   = r_regs[bus.Dbg_Sel];

endmodule
`default_nettype wire

// File: tb/tb_alu_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_sequencer
//  Description : Directed self-checking bench for alu_sequencer. Provides a
//                16-byte instruction ROM and a behavioural 8-bit ALU, then
//                runs short hand-assembled programs and compares registers,
//                flags, PC and timing against hand-computed values.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_sequencer;

    logic clk;
    logic rst;

    alu_sequencer_if #(.ADDR_W(4)) bus ();

    alu_sequencer #(.ADDR_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Instruction ROM
    // ------------------------------------------------------------------
    logic [7:0] rom [16];
    assign bus.Instr_Data = rom[bus.Instr_Addr];

    // ------------------------------------------------------------------
    // Behavioural ALU: ADD, SUB, AND, OR, XOR with {N,Z,C,V}
    // ------------------------------------------------------------------
    logic [8:0] alu_s;
    logic [7:0] alu_r;
    logic       alu_c;
    logic       alu_v;

    always_comb begin
        alu_s = 9'h000;
        alu_r = 8'h00;
        alu_c = 1'b0;
        alu_v = 1'b0;
        case (bus.ALU_OP)
            3'b000: begin
                alu_s = {1'b0, bus.ALU_A} + {1'b0, bus.ALU_B};
                alu_r = alu_s[7:0];
                alu_c = alu_s[8];
                alu_v = (bus.ALU_A[7] == bus.ALU_B[7]) && (alu_r[7] != bus.ALU_A[7]);
            end
            3'b001: begin
                alu_s = {1'b0, bus.ALU_A} - {1'b0, bus.ALU_B};
                alu_r = alu_s[7:0];
                alu_c = ~alu_s[8];
                alu_v = (bus.ALU_A[7] != bus.ALU_B[7]) && (alu_r[7] != bus.ALU_A[7]);
            end
            3'b010:  alu_r = bus.ALU_A & bus.ALU_B;
            3'b011:  alu_r = bus.ALU_A | bus.ALU_B;
            3'b100:  alu_r = bus.ALU_A ^ bus.ALU_B;
            default: alu_r = 8'h00;
        endcase
    end

    assign bus.ALU_Result = alu_r;
    assign bus.ALU_NZCV   = {alu_r[7], (alu_r == 8'h00), alu_c, alu_v};

    // ------------------------------------------------------------------
    // Checking helpers
    // ------------------------------------------------------------------
    int total;
    int bad;
    int n_op_nz;    // cycles with a nonzero ALU_OP during the last run
    int n_op_and;   // cycles with ALU_OP == 010 during the last run
    int edges;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reg(input int idx, input logic [7:0] exp, input string tag);
        bus.Dbg_Sel = idx[1:0];
        #1;
        check(tag, {24'h0, bus.Dbg_Data}, {24'h0, exp});
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 16; i++) rom[i] = 8'h00;
    endtask

    // Pulse start so it is sampled on one edge, then count edges until
    // Halted rises (bounded). Optionally re-pulses start mid-run.
    task automatic run_prog(input int bound, input bit poke_busy, output int n);
        n_op_nz  = 0;
        n_op_and = 0;
        n        = 0;
        @(negedge clk);
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        while (n < bound) begin
            @(posedge clk);
            #1;
            n++;
            if (bus.ALU_OP != 3'b000) n_op_nz++;
            if (bus.ALU_OP == 3'b010) n_op_and++;
            if (poke_busy && n == 4) bus.start = 1'b1;
            if (n == 5) bus.start = 1'b0;
            if (bus.Halted) break;
        end
        check("halted_reached", {31'h0, bus.Halted}, 32'h1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // ------------------------------------------------------------------
    // Directed sequence
    // ------------------------------------------------------------------
    initial begin
        total       = 0;
        bad         = 0;
        rst         = 1'b1;
        bus.start   = 1'b0;
        bus.Dbg_Sel = 2'd0;
        clear_rom();

        // Reset state
        @(negedge clk);
        @(negedge clk);
        check("rst_busy",   {31'h0, bus.Busy},   32'h0);
        check("rst_halted", {31'h0, bus.Halted}, 32'h0);
        check("rst_aluop",  {29'h0, bus.ALU_OP}, 32'h0);
        check("rst_flags",  {28'h0, bus.Flags},  32'h0);
        check("rst_pc",     {28'h0, bus.Instr_Addr}, 32'h0);
        check("rst_alua",   {24'h0, bus.ALU_A},  32'h0);
        rst = 1'b0;
        @(negedge clk);

        // Test 1: LDI R0,E4 ; LDI R1,A2 ; ADD R0,R1 ; HALT
        // E4+A2 = 0x186 -> R0=86, N=1 Z=0 C=1 V=0.
        // A start pulse while busy must not disturb the 12-edge timing.
        rom[0] = 8'hC0; rom[1] = 8'hE4; rom[2] = 8'hC8;
        rom[3] = 8'hA2; rom[4] = 8'h02; rom[5] = 8'hE0;
        run_prog(40, 1'b1, edges);
        check("t1_edges",  edges, 32'd12);
        check("t1_flags",  {28'h0, bus.Flags}, 32'hA);
        check("t1_pc",     {28'h0, bus.Instr_Addr}, 32'h6);
        check("t1_busy",   {31'h0, bus.Busy}, 32'h0);
        check("t1_add_op", n_op_nz, 32'd0);
        check_reg(0, 8'h86, "t1_r0");
        check_reg(1, 8'hA2, "t1_r1");

        // Test 3 + restart from HALTED: MOV R3,R0 (101_11_00_0 = B8) ; HALT
        // Registers and Flags retained, ALU_OP never driven.
        clear_rom();
        rom[0] = 8'hB8; rom[1] = 8'hE0;
        run_prog(40, 1'b0, edges);
        check("t3_edges", edges, 32'd5);
        check("t3_flags", {28'h0, bus.Flags}, 32'hA);
        check("t3_aluop", n_op_nz, 32'd0);
        check("t3_pc",    {28'h0, bus.Instr_Addr}, 32'h2);
        check_reg(3, 8'h86, "t3_r3");
        check_reg(0, 8'h86, "t3_r0_kept");
        check_reg(1, 8'hA2, "t3_r1_kept");

        // Test 4: reset during EXEC of ADD (state after edge 8 of the run)
        clear_rom();
        rom[0] = 8'hC0; rom[1] = 8'hE4; rom[2] = 8'hC8;
        rom[3] = 8'hA2; rom[4] = 8'h02; rom[5] = 8'hE0;
        @(negedge clk);
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (8) @(posedge clk);
        #2;
        check("t4_opa",  {24'h0, bus.ALU_A}, 32'hE4);
        check("t4_opb",  {24'h0, bus.ALU_B}, 32'hA2);
        check("t4_busy_pre", {31'h0, bus.Busy}, 32'h1);
        rst = 1'b1;
        #1;
        check("t4_busy",  {31'h0, bus.Busy},  32'h0);
        check("t4_flags", {28'h0, bus.Flags}, 32'h0);
        check("t4_pc",    {28'h0, bus.Instr_Addr}, 32'h0);
        check("t4_halt",  {31'h0, bus.Halted}, 32'h0);
        check_reg(0, 8'h00, "t4_r0");
        check_reg(3, 8'h00, "t4_r3");
        @(negedge clk);
        rst = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        check("t4_idle",  {31'h0, bus.Busy}, 32'h0);
        check_reg(0, 8'h00, "t4_no_wb_r0");
        check_reg(1, 8'h00, "t4_no_wb_r1");

        // Test 2: LDI R2,E6 ; LDI R3,2C ; AND R2,R3 ; HALT
        // E6 & 2C = 24, all flags clear; ALU_OP=010 for exactly one cycle.
        clear_rom();
        rom[0] = 8'hD0; rom[1] = 8'hE6; rom[2] = 8'hD8;
        rom[3] = 8'h2C; rom[4] = 8'h56; rom[5] = 8'hE0;
        run_prog(40, 1'b0, edges);
        check("t2_edges",  edges, 32'd12);
        check("t2_flags",  {28'h0, bus.Flags}, 32'h0);
        check("t2_and1",   n_op_and, 32'd1);
        check("t2_opnz",   n_op_nz, 32'd1);
        check_reg(2, 8'h24, "t2_r2");
        check_reg(3, 8'h2C, "t2_r3");

        // Test 5: PC wrap. addr0=5A (AND R3,R1), 1..14 MOV R0,R0 (A0),
        // 15 LDI R1 whose immediate is fetched from addr 0.
        // Timing: 4 + 14*3 + 3 = 49 edges to the IMM write.
        do_reset();
        clear_rom();
        rom[0] = 8'h5A;
        for (int i = 1; i < 15; i++) rom[i] = 8'hA0;
        rom[15] = 8'hC8;
        bus.Dbg_Sel = 2'd1;
        @(negedge clk);
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        edges = 0;
        while (edges < 80) begin
            @(posedge clk);
            #1;
            edges++;
            if (bus.Dbg_Data == 8'h5A) break;
        end
        check("t5_r1",    {24'h0, bus.Dbg_Data}, 32'h5A);
        check("t5_edges", edges, 32'd49);
        check("t5_pc",    {28'h0, bus.Instr_Addr}, 32'h1);
        check("t5_flags", {28'h0, bus.Flags}, 32'h4);
        do_reset();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
